// File: rtl/fpu_issue_stage.sv
// Buffered issue/writeback stage around the combinational shader FPU:
// input FIFO -> registered issue slot (S1) -> registered writeback slot (S2).
module fpu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_a_i,
  input  logic [WIDTH-1:0]           in_b_i,
  input  logic [2:0]                 in_op_i,
  input  logic [TAG_W-1:0]           in_tag_i,
  output logic [WIDTH-1:0]           fpu_a_o,
  output logic [WIDTH-1:0]           fpu_b_o,
  output logic [2:0]                 fpu_ctrl_o,
  input  logic [WIDTH-1:0]           fpu_out_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [WIDTH-1:0]           wb_data_o,
  output logic [TAG_W-1:0]           wb_tag_o,
  output logic                       wb_illegal_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [2:0]  OP_ILLEGAL = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Idle issue slot presents the illegal op so the FPU output stays 0.
  localparam entry_t IDLE_ENTRY = '{a: '0, b: '0, op: OP_ILLEGAL, tag: '0};

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            s1_valid;
  entry_t          s1;
  logic            s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic [TAG_W-1:0] s2_tag;
  logic            s2_illegal;

  logic push;
  logic pop;
  logic adv1;
  logic adv2;

  assign in_ready_o = (count != CW'(DEPTH));
  assign push       = in_valid_i && in_ready_o;
  assign adv2       = !s2_valid || wb_ready_i;
  assign adv1       = !s1_valid || adv2;
  assign pop        = adv1 && (count != '0);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a_i, b: in_b_i, op: in_op_i, tag: in_tag_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1       <= IDLE_ENTRY;
    end else if (adv1) begin
      s1_valid <= pop;
      s1       <= pop ? mem[rd_ptr] : IDLE_ENTRY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      s2_tag     <= '0;
      s2_illegal <= 1'b0;
    end else if (adv2) begin
      s2_valid   <= s1_valid;
      s2_data    <= s1_valid ? fpu_out_i : '0;
      s2_tag     <= s1.tag;
      s2_illegal <= s1_valid && (s1.op == OP_ILLEGAL);
    end
  end

  assign fpu_a_o      = s1.a;
  assign fpu_b_o      = s1.b;
  assign fpu_ctrl_o   = s1.op;
  assign wb_valid_o   = s2_valid;
  assign wb_data_o    = s2_data;
  assign wb_tag_o     = s2_tag;
  assign wb_illegal_o = s2_illegal;
  assign busy_o       = (count != '0) || s1_valid || s2_valid;
  assign count_o      = count;

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Randomised and directed bench for fpu_issue_stage with a behavioural FPU
// stand-in and an in-order scoreboard of expected writebacks.
module tb_fpu_issue_stage;

  localparam int unsigned W = 32;
  localparam int unsigned T = 5;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic [T-1:0] in_tag;
  logic [W-1:0] fpu_a;
  logic [W-1:0] fpu_b;
  logic [2:0]   fpu_ctrl;
  logic [W-1:0] fpu_out;
  logic         wb_valid;
  logic         wb_ready;
  logic [W-1:0] wb_data;
  logic [T-1:0] wb_tag;
  logic         wb_illegal;
  logic         busy;
  logic [2:0]   count;

  always #5 clk = ~clk;

  fpu_issue_stage #(.WIDTH(W), .TAG_W(T), .DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_op_i(in_op), .in_tag_i(in_tag),
    .fpu_a_o(fpu_a), .fpu_b_o(fpu_b), .fpu_ctrl_o(fpu_ctrl), .fpu_out_i(fpu_out),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_data_o(wb_data), .wb_tag_o(wb_tag), .wb_illegal_o(wb_illegal),
    .busy_o(busy), .count_o(count)
  );

  // Single precision <-> real for normal numbers (operands kept in a safe exponent range).
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] bits;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    bits = $realtobits(r);
    e = bits[62:52] - 11'd896;
    return {bits[63], e[7:0], bits[51:29]};
  endfunction

  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    real ra;
    real rb;
    ra = sp2r(a);
    rb = sp2r(b);
    case (op)
      3'b000:  return r2sp(ra + rb);
      3'b001:  return r2sp(ra - rb);
      3'b010:  return r2sp(ra * rb);
      3'b011:  return (ra >= rb) ? a : b;
      3'b100:  return (ra <= rb) ? a : b;
      3'b101:  return {1'b0, a[30:0]};
      3'b110:  return {~a[31], a[30:0]};
      default: return 32'h0;
    endcase
  endfunction

  assign fpu_out = fpu_model(fpu_a, fpu_b, fpu_ctrl);

  typedef struct {
    logic [W-1:0] data;
    logic [T-1:0] tag;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  exp_t pending;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_no   = 0;
  int   ret_cycles[$];
  bit   accepted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: record handshakes at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_wb", 64'(wb_data), 64'hdead);
      end else begin
        e = sb.pop_front();
        check("wb_data", 64'(wb_data), 64'(e.data));
        check("wb_tag", 64'(wb_tag), 64'(e.tag));
        check("wb_illegal", 64'(wb_illegal), 64'(e.ill));
      end
      ret_cycles.push_back(cyc_no);
    end
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back(pending);
    @(posedge clk);
    #1;
    cyc_no++;
    check("busy", 64'(busy), 64'(sb.size() != 0));
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [T-1:0] tag, input logic [31:0] exp_data);
    in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
    pending = '{data: exp_data, tag: tag, ill: (op == 3'b111)};
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [T-1:0] tag, input logic [31:0] exp_data);
    int n = 0;
    offer(a, b, op, tag, exp_data);
    do begin
      tick();
      n++;
    end while (!accepted && n < 50);
    if (!accepted) check("push_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(120, 134));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic offer_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    a  = rnd_fp();
    b  = rnd_fp();
    op = 3'($urandom_range(0, 7));
    offer(a, b, op, T'($urandom), fpu_model(a, b, op));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Hold wb_ready low and offer up to 7 ops for 12 cycles; returns number accepted.
  task automatic fill_stalled(output int k);
    k = 0;
    wb_ready = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!in_valid && k < 7) offer_random();
      tick();
      if (accepted) begin
        k++;
        in_valid = 1'b0;
      end
    end
    if (k < 7 && !in_valid) offer_random();
  endtask

  initial begin
    int k;
    rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_fpu_ctrl", 64'(fpu_ctrl), 64'd7);
    check("rst_count", 64'(count), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add latency
    push_op(32'h3F800000, 32'h40000000, 3'b000, 5'd3, 32'h40400000);
    in_valid = 1'b0;
    check("add_wb_valid_e0", 64'(wb_valid), 64'd0);
    tick();
    check("add_wb_valid_e1", 64'(wb_valid), 64'd0);
    check("add_fpu_ctrl_e1", 64'(fpu_ctrl), 64'd0);
    check("add_fpu_a_e1", 64'(fpu_a), 64'h3F800000);
    tick();
    check("add_wb_valid_e2", 64'(wb_valid), 64'd1);
    check("add_wb_data", 64'(wb_data), 64'h40400000);
    check("add_wb_tag", 64'(wb_tag), 64'd3);
    drain(20);

    // Back-to-back mixed stream, including an illegal op between legal neighbours
    ret_cycles.delete();
    push_op(32'h40000000, 32'h40400000, 3'b010, 5'd1, 32'h40C00000);
    push_op(32'hBF800000, 32'h00000000, 3'b101, 5'd2, 32'h3F800000);
    push_op(32'h3F800000, 32'h00000000, 3'b110, 5'd4, 32'hBF800000);
    push_op(32'h40400000, 32'h3F800000, 3'b001, 5'd5, 32'h40000000);
    push_op(32'h3F800000, 32'h40000000, 3'b111, 5'd9, 32'h00000000);
    push_op(32'h3F800000, 32'h40000000, 3'b011, 5'd6, 32'h40000000);
    push_op(32'h3F800000, 32'h40000000, 3'b100, 5'd7, 32'h3F800000);
    push_op(32'h40000000, 32'h40000000, 3'b000, 5'd8, 32'h40800000);
    drain(30);
    check("stream_results", 64'(ret_cycles.size()), 64'd8);
    if (ret_cycles.size() == 8)
      check("stream_consecutive", 64'(ret_cycles[7] - ret_cycles[0]), 64'd7);

    // Backpressure fill, then full FIFO with pop and push offered together
    fill_stalled(k);
    check("bp_accepted", 64'(k), 64'd6);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_count", 64'(count), 64'd4);
    wb_ready = 1'b1;
    tick();
    check("full_push_refused", 64'(accepted), 64'd0);
    check("full_pop_count", 64'(count), 64'd3);
    wb_ready = 1'b0;
    tick();
    check("refill_accepted", 64'(accepted), 64'd1);
    check("refill_count", 64'(count), 64'd4);
    in_valid = 1'b0;

    // Asynchronous reset mid-stall with 6 ops in flight
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_wb_valid", 64'(wb_valid), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_fpu_ctrl", 64'(fpu_ctrl), 64'd7);
    check("mid_rst_wb_data", 64'(wb_data), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b1;
    repeat (6) tick();

    // Backpressure release: everything drains in order
    fill_stalled(k);
    check("bp2_accepted", 64'(k), 64'd6);
    wb_ready = 1'b1;
    k = 0;
    while (in_valid && k < 20) begin
      tick();
      k++;
      if (accepted) in_valid = 1'b0;
    end
    check("bp2_seventh_accepted", 64'(in_valid), 64'd0);
    drain(30);

    // Random traffic with random backpressure
    in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) offer_random();
      wb_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (accepted) in_valid = 1'b0;
    end
    drain(50);
    check("final_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
